b8to1_serializer: RTL and testbench



---
 rtl/b8to1_serializer_pkg.sv | 13 +
 rtl/b8to1_muxer.sv | 14 +
 rtl/b8to1_serializer.sv | 79 +++++++
 tb/tb_b8to1_serializer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/b8to1_serializer_pkg.sv
// Shared definitions for the byte-to-bit serializer: state encoding and word geometry.
package b8to1_serializer_pkg;

    localparam int WORD_BITS = 8;
    localparam int SEL_BITS  = $clog2(WORD_BITS);
    localparam logic [SEL_BITS-1:0] LAST_BEAT = SEL_BITS'(WORD_BITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/b8to1_muxer.sv
// 8-to-1 bit multiplexer: z is the bit of x picked by sel.
module b8to1_muxer
    import b8to1_serializer_pkg::*;
(
    input  logic [WORD_BITS-1:0] x,
    input  logic [SEL_BITS-1:0]  sel,
    output logic                 z
);

    always_comb begin
        z = x[sel];
    end

endmodule

// File: rtl/b8to1_serializer.sv
// Parallel-to-serial converter: takes a byte on a valid/ready input and emits it
// one bit per accepted beat; the beat counter drives the select of an 8-to-1 mux.
module b8to1_serializer
    import b8to1_serializer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset_,
    input  logic [WORD_BITS-1:0] x7_x0,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 z0,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 last
);

    state_t                 state_q, state_d;
    logic [WORD_BITS-1:0]   word_q,  word_d;
    logic [SEL_BITS-1:0]    count_q, count_d;
    logic [SEL_BITS-1:0]    sel;
    logic                   at_last_beat;

    assign at_last_beat = (count_q == LAST_BEAT);

    // in_ready looks through to out_ready so a new word can reload on the final beat.
    assign in_ready  = (state_q == IDLE) | ((state_q == SEND) & at_last_beat & out_ready);
    assign out_valid = (state_q == SEND);
    assign last      = (state_q == SEND) & at_last_beat;
    assign sel       = MSB_FIRST ? ~count_q : count_q;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SEND;
                    word_d  = x7_x0;
                    count_d = '0;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (!at_last_beat) begin
                        count_d = count_q + 1'b1;
                    end else if (in_valid) begin
                        word_d  = x7_x0;
                        count_d = '0;
                    end else begin
                        // word and count hold so z0 keeps the last emitted bit
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q <= IDLE;
            word_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

    b8to1_muxer u_muxer (
        .x   (word_q),
        .sel (sel),
        .z   (z0)
    );

endmodule

// File: tb/tb_b8to1_serializer.sv
// Randomized and directed checks of both bit orders against a queue-based bit-stream model.
module tb_b8to1_serializer;

    logic       clock;
    logic       reset_;
    logic [7:0] x7_x0;
    logic       in_valid;
    logic       out_ready;

    logic ir_l, z_l, ov_l, last_l;
    logic ir_m, z_m, ov_m, last_m;

    int checks = 0;
    int errors = 0;

    // Model: pending output bits per order, plus the bit z0 holds when idle.
    bit q_l[$];
    bit q_m[$];
    bit held_l = 1'b0;
    bit held_m = 1'b0;
    bit armed  = 1'b0;

    b8to1_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
        .clock     (clock),
        .reset_    (reset_),
        .x7_x0     (x7_x0),
        .in_valid  (in_valid),
        .in_ready  (ir_l),
        .z0        (z_l),
        .out_valid (ov_l),
        .out_ready (out_ready),
        .last      (last_l)
    );

    b8to1_serializer #(.MSB_FIRST(1'b1)) dut_msb (
        .clock     (clock),
        .reset_    (reset_),
        .x7_x0     (x7_x0),
        .in_valid  (in_valid),
        .in_ready  (ir_m),
        .z0        (z_m),
        .out_valid (ov_m),
        .out_ready (out_ready),
        .last      (last_m)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, then advance the model.
    task automatic step(input bit iv, input logic [7:0] x, input bit ordy, input bit rst_n);
        bit exp_ir, exp_ov, exp_last, exp_zl, exp_zm, in_x, out_x;
        in_valid  = iv;
        x7_x0     = x;
        out_ready = ordy;
        reset_    = rst_n;
        #2;
        exp_ov   = (q_l.size() != 0);
        exp_ir   = (q_l.size() == 0) || (q_l.size() == 1 && ordy);
        exp_last = (q_l.size() == 1);
        exp_zl   = exp_ov ? q_l[0] : held_l;
        exp_zm   = exp_ov ? q_m[0] : held_m;
        if (armed) begin
            check("in_ready_lsb",  {7'b0, ir_l},   {7'b0, exp_ir});
            check("in_ready_msb",  {7'b0, ir_m},   {7'b0, exp_ir});
            check("out_valid_lsb", {7'b0, ov_l},   {7'b0, exp_ov});
            check("out_valid_msb", {7'b0, ov_m},   {7'b0, exp_ov});
            check("last_lsb",      {7'b0, last_l}, {7'b0, exp_last});
            check("last_msb",      {7'b0, last_m}, {7'b0, exp_last});
            check("z0_lsb",        {7'b0, z_l},    {7'b0, exp_zl});
            check("z0_msb",        {7'b0, z_m},    {7'b0, exp_zm});
        end
        @(posedge clock);
        if (!rst_n) begin
            q_l.delete();
            q_m.delete();
            held_l = 1'b0;
            held_m = 1'b0;
            armed  = 1'b1;
        end else if (armed) begin
            out_x = exp_ov && ordy;
            in_x  = iv && exp_ir;
            if (out_x) begin
                held_l = q_l.pop_front();
                held_m = q_m.pop_front();
            end
            if (in_x) begin
                $display("accept word %02h at %0t", x, $time);
                for (int i = 0; i < 8; i++) begin
                    q_l.push_back(x[i]);
                    q_m.push_back(x[7-i]);
                end
            end
        end
        #1;
    endtask

    bit pat [14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        int n;
        logic [7:0] seq;
        in_valid  = 1'b0;
        x7_x0     = 8'h00;
        out_ready = 1'b0;
        reset_    = 1'b0;
        @(posedge clock);
        #1;
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 1);

        // Single word A5, LSB-first sequence assembled from the serial stream
        step(1, 8'hA5, 1, 1);
        seq = 8'h00;
        for (int i = 0; i < 8; i++) begin
            seq[i] = z_l;
            step(0, 8'h5A, 1, 1);
        end
        check("a5_sequence", seq, 8'hA5);
        step(0, 8'h00, 1, 1);

        // Word 81: MSB-first stream should read 1,0,0,0,0,0,0,1
        step(1, 8'h81, 1, 1);
        for (int i = 0; i < 8; i++) begin
            seq[7-i] = z_m;
            step(0, 8'h00, 1, 1);
        end
        check("81_msb_sequence", seq, 8'h81);

        // Backpressure on 3C: stalls of 3 cycles on beats 2 and 5
        step(1, 8'h3C, 1, 1);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (!ov_l) break;
            n++;
            step(0, 8'($urandom), (i < 14) ? pat[i] : 1'b1, 1);
        end
        check("stall_cycles", 8'(n), 8'd14);

        // Back-to-back FF then 00 with no bubble
        step(1, 8'hFF, 1, 1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!ov_l) break;
            n++;
            step(i < 8, 8'h00, 1, 1);
        end
        check("stream_cycles", 8'(n), 8'd16);

        // Reset after beat 3 of F0, then 0F from bit 0
        step(1, 8'hF0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 1);
        step(0, 8'h00, 1, 0);
        step(1, 8'h0F, 1, 1);
        seq = 8'h00;
        for (int i = 0; i < 8; i++) begin
            seq[i] = z_l;
            step(0, 8'h00, 1, 1);
        end
        check("0f_after_reset", seq, 8'h0F);

        // Idle with toggling data
        for (int i = 0; i < 10; i++) step(0, 8'($urandom), 1'($urandom), 1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
